mul_pipe: RTL and testbench

//  Pipelined, handshaked multiplier built around the combinational tree multiplier 'mul'.

---
 rtl/mul_pipe_pkg.sv | 12 +
 rtl/mul_pipe_if.sv | 28 ++
 rtl/mul_pipe_mul.sv | 27 ++
 rtl/mul_pipe.sv | 114 +++++++++++
 tb/tb_mul_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipe_pkg.sv
// rtl/mul_pipe_pkg.sv - default widths and operand-mode encoding for the pipelined multiplier
package configure;
    localparam int XLEN   = 32;
    localparam int TYP    = 0;
    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        MUL_UU = 2'b00,
        MUL_SS = 2'b01,
        MUL_SU = 2'b10
    } mul_op_t;
endpackage

// File: rtl/mul_pipe_if.sv
// rtl/mul_pipe_if.sv - issue-side and writeback-side handshake bundle of the multiplier
interface mul_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
);
    import configure::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_a;
    logic [XLEN-1:0]     in_b;
    logic [1:0]          in_op;
    logic [TAGW-1:0]     in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [2*XLEN-1:0]   out_p;
    logic [TAGW-1:0]     out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/mul_pipe_mul.sv
// rtl/mul_pipe_mul.sv - combinational unsigned XLEN x XLEN multiplier, reduction style chosen by TYP
module mul #(
    parameter int XLEN = 32,
    parameter int TYP  = 0
) (
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_p
);
    generate
        if (TYP == 0) begin : g_tree
            // Operator form: the synthesis tool builds its own reduction tree.
            assign o_p = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
        end else begin : g_array
            logic [2*XLEN-1:0] w_acc;
            always_comb begin
                w_acc = '0;
                for (int i = 0; i < XLEN; i++) begin
                    if (i_b[i]) begin
                        w_acc = w_acc + ({{XLEN{1'b0}}, i_a} << i);
                    end
                end
            end
            assign o_p = w_acc;
        end
    endgenerate
endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - STAGES-deep handshaked multiplier with signed/unsigned/mixed modes and a carried tag
module mul_pipe #(
    parameter int XLEN   = configure::XLEN,
    parameter int TYP    = configure::TYP,
    parameter int STAGES = configure::STAGES,
    parameter int TAGW   = 4
) (
    input  logic      clock,
    input  logic      reset,
    mul_pipe_if.slave bus
);
    import configure::*;

    logic                              w_adv;
    logic                              w_sa;
    logic                              w_sb;
    logic [XLEN-1:0]                   w_abs_a;
    logic [XLEN-1:0]                   w_abs_b;
    logic [2*XLEN-1:0]                 w_mul_p;
    logic [STAGES-1:1]                 w_vld_at;
    logic [STAGES-1:1]                 w_neg_at;
    logic [STAGES-1:1][TAGW-1:0]       w_tag_at;
    logic [STAGES-1:1][2*XLEN-1:0]     w_prod_at;

    logic [XLEN-1:0]                   r_ma;
    logic [XLEN-1:0]                   r_mb;
    logic                              r_vld1;
    logic                              r_neg1;
    logic [TAGW-1:0]                   r_tag1;
    logic                              r_out_vld;
    logic [TAGW-1:0]                   r_out_tag;
    logic [2*XLEN-1:0]                 r_out_p;

    // One global stall: the whole pipe moves only when the output slot can drain.
    assign w_adv        = !r_out_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_sa    = bus.in_a[XLEN-1] && (bus.in_op == MUL_SS || bus.in_op == MUL_SU);
    assign w_sb    = bus.in_b[XLEN-1] && (bus.in_op == MUL_SS);
    assign w_abs_a = w_sa ? -bus.in_a : bus.in_a;
    assign w_abs_b = w_sb ? -bus.in_b : bus.in_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ma   <= '0;
            r_mb   <= '0;
            r_vld1 <= 1'b0;
            r_neg1 <= 1'b0;
            r_tag1 <= '0;
        end else if (w_adv) begin
            r_ma   <= w_abs_a;
            r_mb   <= w_abs_b;
            r_vld1 <= bus.in_valid;
            r_neg1 <= w_sa ^ w_sb;
            r_tag1 <= bus.in_tag;
        end
    end

    mul #(.XLEN(XLEN), .TYP(TYP)) u_mul (
        .i_a (r_ma),
        .i_b (r_mb),
        .o_p (w_mul_p)
    );

    assign w_vld_at[1]  = r_vld1;
    assign w_neg_at[1]  = r_neg1;
    assign w_tag_at[1]  = r_tag1;
    assign w_prod_at[1] = w_mul_p;

    generate
        for (genvar s = 2; s < STAGES; s++) begin : g_mid
            logic              r_vld;
            logic              r_neg;
            logic [TAGW-1:0]   r_tag;
            logic [2*XLEN-1:0] r_prod;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_vld  <= 1'b0;
                    r_neg  <= 1'b0;
                    r_tag  <= '0;
                    r_prod <= '0;
                end else if (w_adv) begin
                    r_vld  <= w_vld_at[s-1];
                    r_neg  <= w_neg_at[s-1];
                    r_tag  <= w_tag_at[s-1];
                    r_prod <= w_prod_at[s-1];
                end
            end

            assign w_vld_at[s]  = r_vld;
            assign w_neg_at[s]  = r_neg;
            assign w_tag_at[s]  = r_tag;
            assign w_prod_at[s] = r_prod;
        end
    endgenerate

    // Sign is re-applied only at the very end so the middle slots move plain magnitudes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_vld <= 1'b0;
            r_out_tag <= '0;
            r_out_p   <= '0;
        end else if (w_adv) begin
            r_out_vld <= w_vld_at[STAGES-1];
            r_out_tag <= w_tag_at[STAGES-1];
            r_out_p   <= w_neg_at[STAGES-1] ? -w_prod_at[STAGES-1] : w_prod_at[STAGES-1];
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_p     = r_out_p;
endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - directed and randomised self-checking bench for mul_pipe
module tb_mul_pipe;
    localparam int XLEN   = 32;
    localparam int STAGES = 3;
    localparam int TAGW   = 4;
    localparam int NRAND  = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    mul_pipe #(.XLEN(XLEN), .TYP(0), .STAGES(STAGES), .TAGW(TAGW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    logic [63:0]     exp_p_q[$];
    logic [TAGW-1:0] exp_tag_q[$];
    logic            held_v = 1'b0;
    logic [63:0]     held_p;
    logic [TAGW-1:0] held_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hffff_ffff;
            3:       return 32'h8000_0000;
            4:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard, hold-stability and backpressure monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_p_q.delete();
            exp_tag_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_p", bus.out_p, held_p);
                check("hold_tag", bus.out_tag, held_tag);
            end
            if (bus.out_valid && !bus.out_ready)
                check("bp_in_ready", bus.in_ready, 0);
            held_v   = bus.out_valid && !bus.out_ready;
            held_p   = bus.out_p;
            held_tag = bus.out_tag;
            if (bus.in_valid && bus.in_ready) begin
                exp_p_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
                exp_tag_q.push_back(bus.in_tag);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_p_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 0);
                end else begin
                    check("model_p", bus.out_p, exp_p_q.pop_front());
                    check("model_tag", bus.out_tag, exp_tag_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [63:0] exp);
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        cyc = 0;
        do begin
            tick();
            cyc++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && cyc < 20);
        check({name, "_latency"}, cyc, STAGES);
        check({name, "_p"}, bus.out_p, exp);
        check({name, "_tag"}, bus.out_tag, tag);
        tick();
    endtask

    initial begin
        int sent;
        int base;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_p", bus.out_p, 0);
        check("rst_out_tag", bus.out_tag, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;

        single("uu_max",   2'b00, 32'hffff_ffff, 32'hffff_ffff, 4'h1, 64'hffff_fffe_0000_0001);
        single("ss_m1m1",  2'b01, 32'hffff_ffff, 32'hffff_ffff, 4'h2, 64'h0000_0000_0000_0001);
        single("ss_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 4'h3, 64'h4000_0000_0000_0000);
        single("su_m1",    2'b10, 32'hffff_ffff, 32'hffff_ffff, 4'h4, 64'hffff_ffff_0000_0001);
        single("su_pos",   2'b10, 32'h0000_0002, 32'h8000_0000, 4'h5, 64'h0000_0001_0000_0000);
        single("ss_mixed", 2'b01, 32'h7fff_ffff, 32'h8000_0000, 4'h6, 64'hc000_0000_8000_0000);
        single("op11_uu",  2'b11, 32'hffff_ffff, 32'h0000_0002, 4'h7, 64'h0000_0001_ffff_fffe);
        single("uu_zero",  2'b00, 32'h0000_0000, 32'hffff_ffff, 4'h8, 64'h0);

        // Backpressure: tags 0..7 streamed, consumer stalls for cycles 4..8.
        sent = 0;
        base = n_out;
        for (int t = 0; t < 60 && (sent < 8 || exp_p_q.size() != 0); t++) begin
            bus.out_ready = !(t >= 4 && t <= 8);
            bus.in_valid  = (sent < 8);
            bus.in_a      = 32'(sent * 3 + 7);
            bus.in_b      = 32'hffff_fff0 + 32'(sent);
            bus.in_op     = 2'(sent % 3);
            bus.in_tag    = 4'(sent);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_sent", sent, 8);
        check("bp_received", n_out - base, 8);

        // Reset lands on the third op of a burst; nothing of the burst may emerge.
        base = n_out;
        for (int t = 0; t < 3; t++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'b00;
            bus.in_a     = 32'(t + 100);
            bus.in_b     = 32'(t + 200);
            bus.in_tag   = 4'(t + 9);
            if (t == 2) rst = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_p", bus.out_p, 0);
        check("rst_mid_tag", bus.out_tag, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready", bus.in_ready, 1);
        for (int t = 0; t < 8; t++) begin
            tick();
            check("rst_drop_valid", bus.out_valid, 0);
        end
        check("rst_drop_count", n_out - base, 0);

        // Random modes, operands and consumer stalls against the model.
        sent = 0;
        base = n_out;
        for (int cyc = 0; cyc < 60000 && (sent < NRAND || exp_p_q.size() != 0); cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            bus.in_a      = pick();
            bus.in_b      = pick();
            bus.in_op     = 2'($urandom_range(0, 3));
            bus.in_tag    = 4'($urandom);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_sent", sent, NRAND);
        check("rand_received", n_out - base, NRAND);
        check("rand_drained", exp_p_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
